// File: rtl/ov7670_cfg_pkg.sv
// Shared definitions for the dual-camera OV7670 configuration sequencer.
// State encodings are stable because they drive the debug LEDs.
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSettleL = 3'd1,
    StStartL  = 3'd2,
    StWaitL   = 3'd3,
    StSettleR = 3'd4,
    StStartR  = 3'd5,
    StWaitR   = 3'd6,
    StDone    = 3'd7
  } cfg_state_e;

  localparam logic CAM_L = 1'b0;
  localparam logic CAM_R = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov7670_dual_cfg_seq_if.sv
// Controller handshake plus the SCCB pins, both controller-side and per-camera side.
interface ov7670_dual_cfg_seq_if;
  logic cfg_done;
  logic cfg_resend;
  logic ctl_sioc;
  logic ctl_siod_o;
  logic ctl_siod_oe;
  logic ctl_siod_i;
  logic sioc_l;
  logic sioc_r;
  logic siod_o;
  logic siod_oe_l;
  logic siod_oe_r;
  logic siod_i_l;
  logic siod_i_r;

  modport master (
    input  cfg_done, ctl_sioc, ctl_siod_o, ctl_siod_oe, siod_i_l, siod_i_r,
    output cfg_resend, ctl_siod_i, sioc_l, sioc_r, siod_o, siod_oe_l, siod_oe_r
  );

  modport slave (
    output cfg_done, ctl_sioc, ctl_siod_o, ctl_siod_oe, siod_i_l, siod_i_r,
    input  cfg_resend, ctl_siod_i, sioc_l, sioc_r, siod_o, siod_oe_l, siod_oe_r
  );
endinterface

// File: rtl/ov7670_dual_cfg_seq_cycle_timer.sv
// Loadable saturating down-counter; expired while the count sits at zero.
module cycle_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] value,
  output logic             expired
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ov7670_dual_cfg_seq.sv
// Runs one shared SCCB configuration controller over the left then right camera,
// with settle time, per-attempt timeout and bounded retries.
module ov7670_dual_cfg_seq
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned c_settle_cycles  = 50000,
  parameter int unsigned c_timeout_cycles = 5000000,
  parameter int unsigned c_max_retries    = 3,
  parameter int unsigned c_auto_start     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  ov7670_dual_cfg_seq_if.master bus,
  output logic                  cam_sel,
  output logic                  bus_en,
  output logic                  cfg_ok_l,
  output logic                  cfg_ok_r,
  output logic                  cfg_err,
  output logic                  all_done,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int unsigned TimerW = $clog2(max_u(c_settle_cycles, c_timeout_cycles) + 1);
  localparam int unsigned RetryW = (c_max_retries > 0) ? $clog2(c_max_retries + 1) : 1;
  // Timer reaches zero in the last cycle of the phase, so load one less than its length.
  localparam logic [TimerW-1:0] SettleVal  = TimerW'(c_settle_cycles - 1);
  localparam logic [TimerW-1:0] TimeoutVal = TimerW'(c_timeout_cycles - 1);
  localparam logic [RetryW-1:0] MaxRetry   = RetryW'(c_max_retries);

  cfg_state_e        state_q, state_d;
  logic              done_q;
  logic              ok_l_q, ok_l_d, ok_r_q, ok_r_d, err_q, err_d;
  logic [RetryW-1:0] retry_l_q, retry_l_d, retry_r_q, retry_r_d;
  logic              resend_q, resend_d, cam_sel_q, cam_sel_d;
  logic              bus_en_q, bus_en_d, busy_q, busy_d;
  logic              tmr_load, tmr_expired;
  logic [TimerW-1:0] tmr_value;
  logic              done_rise;

  assign done_rise = bus.cfg_done & ~done_q;

  cycle_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    ok_l_d    = ok_l_q;
    ok_r_d    = ok_r_q;
    err_d     = err_q;
    retry_l_d = retry_l_q;
    retry_r_d = retry_r_q;
    tmr_load  = 1'b0;
    tmr_value = SettleVal;

    unique case (state_q)
      StIdle: begin
        if (c_auto_start != 0) begin
          state_d   = StSettleL;
          retry_l_d = '0;
          retry_r_d = '0;
          tmr_load  = 1'b1;
        end
      end
      StSettleL: if (tmr_expired) state_d = StStartL;
      StStartL: begin
        state_d   = StWaitL;
        tmr_load  = 1'b1;
        tmr_value = TimeoutVal;
      end
      StWaitL: begin
        if (done_rise || tmr_expired) begin
          if (done_rise) begin
            ok_l_d = 1'b1;
          end else if (retry_l_q < MaxRetry) begin
            retry_l_d = retry_l_q + RetryW'(1);
          end else begin
            err_d = 1'b1;
          end
          // Retry stays on the left camera; success or give-up hands over to the right.
          state_d   = (!done_rise && retry_l_q < MaxRetry) ? StSettleL : StSettleR;
          retry_r_d = '0;
          tmr_load  = 1'b1;
        end
      end
      StSettleR: if (tmr_expired) state_d = StStartR;
      StStartR: begin
        state_d   = StWaitR;
        tmr_load  = 1'b1;
        tmr_value = TimeoutVal;
      end
      StWaitR: begin
        if (done_rise) begin
          ok_r_d  = 1'b1;
          state_d = StDone;
        end else if (tmr_expired) begin
          if (retry_r_q < MaxRetry) begin
            retry_r_d = retry_r_q + RetryW'(1);
            state_d   = StSettleR;
            tmr_load  = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

    // A start request overrides anything the current state decided this cycle.
    if (start) begin
      state_d   = StSettleL;
      ok_l_d    = 1'b0;
      ok_r_d    = 1'b0;
      err_d     = 1'b0;
      retry_l_d = '0;
      retry_r_d = '0;
      tmr_load  = 1'b1;
      tmr_value = SettleVal;
    end

    resend_d  = (state_d == StStartL) || (state_d == StStartR);
    bus_en_d  = (state_d == StStartL) || (state_d == StWaitL) ||
                (state_d == StStartR) || (state_d == StWaitR);
    busy_d    = (state_d != StIdle) && (state_d != StDone);
    cam_sel_d = cam_sel_q;
    if (state_d == StSettleL) cam_sel_d = CAM_L;
    if (state_d == StSettleR) cam_sel_d = CAM_R;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      done_q    <= 1'b0;
      ok_l_q    <= 1'b0;
      ok_r_q    <= 1'b0;
      err_q     <= 1'b0;
      retry_l_q <= '0;
      retry_r_q <= '0;
      resend_q  <= 1'b0;
      cam_sel_q <= CAM_L;
      bus_en_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= bus.cfg_done;
      ok_l_q    <= ok_l_d;
      ok_r_q    <= ok_r_d;
      err_q     <= err_d;
      retry_l_q <= retry_l_d;
      retry_r_q <= retry_r_d;
      resend_q  <= resend_d;
      cam_sel_q <= cam_sel_d;
      bus_en_q  <= bus_en_d;
      busy_q    <= busy_d;
    end
  end

  // SCCB steering: the unselected camera, or both when released, sees SIOC high and SIOD undriven.
  logic sel_l, sel_r;
  assign sel_l          = bus_en_q && (cam_sel_q == CAM_L);
  assign sel_r          = bus_en_q && (cam_sel_q == CAM_R);
  assign bus.sioc_l     = sel_l ? bus.ctl_sioc : 1'b1;
  assign bus.sioc_r     = sel_r ? bus.ctl_sioc : 1'b1;
  assign bus.siod_o     = bus.ctl_siod_o;
  assign bus.siod_oe_l  = sel_l & bus.ctl_siod_oe;
  assign bus.siod_oe_r  = sel_r & bus.ctl_siod_oe;
  assign bus.ctl_siod_i = !bus_en_q ? 1'b1 : (sel_r ? bus.siod_i_r : bus.siod_i_l);
  assign bus.cfg_resend = resend_q;

  assign cam_sel   = cam_sel_q;
  assign bus_en    = bus_en_q;
  assign cfg_ok_l  = ok_l_q;
  assign cfg_ok_r  = ok_r_q;
  assign cfg_err   = err_q;
  assign all_done  = ok_l_q & ok_r_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ov7670_dual_cfg_seq.sv
// Bench for ov7670_dual_cfg_seq: table and random attempt plans against a timeline model,
// plus hand-written restart, stale-done and reset sequences.
module tb_ov7670_dual_cfg_seq;
  import ov7670_cfg_pkg::*;

  localparam int SETTLE = 4;
  localparam int TMO    = 20;
  localparam int MAXR   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cam_sel, bus_en, cfg_ok_l, cfg_ok_r, cfg_err, all_done, busy;
  logic [2:0] state_dbg;

  ov7670_dual_cfg_seq_if bus();

  ov7670_dual_cfg_seq #(
    .c_settle_cycles (SETTLE),
    .c_timeout_cycles(TMO),
    .c_max_retries   (MAXR),
    .c_auto_start    (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cam_sel  (cam_sel),
    .bus_en   (bus_en),
    .cfg_ok_l (cfg_ok_l),
    .cfg_ok_r (cfg_ok_r),
    .cfg_err  (cfg_err),
    .all_done (all_done),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // cam_sel must never move while the bus is driven on consecutive cycles.
  logic prev_en = 1'b0, prev_sel = 1'b0;
  int   sel_glitches = 0;
  always @(negedge clk) begin
    if (bus_en === 1'b1 && prev_en === 1'b1 && cam_sel !== prev_sel)
      sel_glitches <= sel_glitches + 1;
    prev_en  <= bus_en;
    prev_sel <= cam_sel;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Attempt plan: entry k is the done delay (cycles after cfg_resend) of attempt k, 0 = no done.
  int plan[8];
  int act_t[$];
  bit act_cam[$];
  int exp_t[$];
  bit exp_cam[$];
  bit m_ok_l, m_ok_r, m_err;
  int m_done;

  // Timeline model: settle S, then resend; success after d cycles, else timeout after T+1.
  task automatic model(input int t_entry);
    int t, s, idx;
    t = t_entry;
    idx = 0;
    exp_t.delete();
    exp_cam.delete();
    m_ok_l = 0; m_ok_r = 0; m_err = 0;
    for (int cam = 0; cam < 2; cam++) begin
      for (int a = 0; a <= MAXR; a++) begin
        s = t + SETTLE;
        exp_t.push_back(s);
        exp_cam.push_back(cam == 1);
        if (plan[idx] != 0) begin
          if (cam == 0) m_ok_l = 1; else m_ok_r = 1;
          t = s + plan[idx];
          idx++;
          break;
        end
        idx++;
        t = s + TMO + 1;
        if (a == MAXR) m_err = 1;
      end
    end
    m_done = t;
  endtask

  task automatic run_plan();
    int idx, done_at, n;
    idx = 0; done_at = -1; n = 0;
    act_t.delete();
    act_cam.delete();
    while (state_dbg !== StDone && n < 400) begin
      if (cfg_resend_seen()) begin
        act_t.push_back(cyc);
        act_cam.push_back(cam_sel);
        done_at = (idx < 8 && plan[idx] != 0) ? cyc + plan[idx] : -1;
        idx++;
      end
      bus.cfg_done = (done_at >= 0) && (cyc == done_at - 1);
      @(negedge clk);
      n++;
    end
    bus.cfg_done = 1'b0;
    check("reach_done", state_dbg, StDone);
    check("done_cycle", cyc, m_done);
    check("bus_en_at_done", bus_en, 0);
    check("busy_at_done", busy, 0);
    check("n_resend_vs_model", act_t.size(), exp_t.size());
    for (int i = 0; i < act_t.size() && i < exp_t.size(); i++) begin
      check($sformatf("resend%0d_cycle", i), act_t[i], exp_t[i]);
      check($sformatf("resend%0d_cam", i), act_cam[i], exp_cam[i]);
    end
  endtask

  function automatic bit cfg_resend_seen();
    return bus.cfg_resend === 1'b1;
  endfunction

  task automatic wait_state(input logic [2:0] st, input string name);
    int n;
    n = 0;
    while (state_dbg !== st && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, state_dbg, st);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state_dbg, StIdle);
    check({tag, "_resend"}, bus.cfg_resend, 0);
    check({tag, "_cam_sel"}, cam_sel, 0);
    check({tag, "_bus_en"}, bus_en, 0);
    check({tag, "_ok_l"}, cfg_ok_l, 0);
    check({tag, "_ok_r"}, cfg_ok_r, 0);
    check({tag, "_err"}, cfg_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_all_done"}, all_done, 0);
  endtask

  typedef struct {
    int d0, d1, d2, d3;
    bit ok_l, ok_r, err;
    int resends;
  } vec_t;

  vec_t vecs[6];
  int   t0;

  initial begin
    vecs[0] = '{10, 10, 0, 0, 1'b1, 1'b1, 1'b0, 2};  // auto start, clean pass
    vecs[1] = '{0, 10, 10, 0, 1'b1, 1'b1, 1'b0, 3};  // left retry then success
    vecs[2] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 4};    // retries exhausted on both
    vecs[3] = '{0, 0, 5, 0, 1'b0, 1'b1, 1'b1, 3};    // left gives up, right passes
    vecs[4] = '{2, 20, 0, 0, 1'b1, 1'b1, 1'b0, 2};   // earliest and latest in-window done
    vecs[5] = '{10, 0, 10, 0, 1'b1, 1'b1, 1'b0, 3};  // right retry then success

    bus.cfg_done    = 1'b0;
    bus.ctl_sioc    = 1'b0;
    bus.ctl_siod_o  = 1'b0;
    bus.ctl_siod_oe = 1'b1;
    bus.siod_i_l    = 1'b0;
    bus.siod_i_r    = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    for (int i = 0; i < 6; i++) begin
      plan = '{default: 0};
      plan[0] = vecs[i].d0; plan[1] = vecs[i].d1;
      plan[2] = vecs[i].d2; plan[3] = vecs[i].d3;
      t0 = cyc + 1;
      if (i == 0) rst = 1'b0; else start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model(t0);
      run_plan();
      check($sformatf("vec%0d_ok_l", i), cfg_ok_l, vecs[i].ok_l);
      check($sformatf("vec%0d_ok_r", i), cfg_ok_r, vecs[i].ok_r);
      check($sformatf("vec%0d_err", i), cfg_err, vecs[i].err);
      check($sformatf("vec%0d_all_done", i), all_done, vecs[i].ok_l & vecs[i].ok_r);
      check($sformatf("vec%0d_resends", i), act_t.size(), vecs[i].resends);
    end

    for (int r = 0; r < 6; r++) begin
      plan = '{default: 0};
      for (int j = 0; j < 4; j++)
        plan[j] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, TMO));
      t0 = cyc + 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model(t0);
      run_plan();
      check($sformatf("rnd%0d_ok_l", r), cfg_ok_l, m_ok_l);
      check($sformatf("rnd%0d_ok_r", r), cfg_ok_r, m_ok_r);
      check($sformatf("rnd%0d_err", r), cfg_err, m_err);
      check($sformatf("rnd%0d_all_done", r), all_done, m_ok_l & m_ok_r);
    end

    // Restart priority: start and a done edge together in WAIT_R.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(StWaitL, "prio_reach_wait_l");
    bus.cfg_done = 1'b1;
    @(negedge clk);
    bus.cfg_done = 1'b0;
    check("prio_ok_l_set", cfg_ok_l, 1);
    check("prio_settle_r", state_dbg, StSettleR);
    check("prio_cam_sel_r", cam_sel, 1);
    wait_state(StWaitR, "prio_reach_wait_r");
    start = 1'b1;
    bus.cfg_done = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.cfg_done = 1'b0;
    check("prio_state", state_dbg, StSettleL);
    check("prio_ok_l_clr", cfg_ok_l, 0);
    check("prio_ok_r_clr", cfg_ok_r, 0);
    check("prio_err_clr", cfg_err, 0);
    check("prio_cam_sel", cam_sel, 0);
    check("prio_bus_en", bus_en, 0);
    check("prio_busy", busy, 1);

    // Stale done: level already high before START_L must not count.
    bus.cfg_done = 1'b1;
    check("mux_settle_sioc_l", bus.sioc_l, 1);
    check("mux_settle_oe_l", bus.siod_oe_l, 0);
    check("mux_settle_siod_i", bus.ctl_siod_i, 1);
    wait_state(StStartL, "stale_reach_start");
    repeat (TMO) @(negedge clk);
    check("stale_still_wait", state_dbg, StWaitL);
    check("stale_no_ok_wait", cfg_ok_l, 0);
    @(negedge clk);
    check("stale_timeout_retry", state_dbg, StSettleL);
    check("stale_no_ok", cfg_ok_l, 0);
    check("stale_no_err", cfg_err, 0);
    bus.cfg_done = 1'b0;

    // Reset mid-WAIT_L, with SCCB steering checked while the left bus is driven.
    wait_state(StWaitL, "rstw_reach_wait_l");
    #1;
    check("mux_wait_sioc_l", bus.sioc_l, 0);
    check("mux_wait_sioc_r", bus.sioc_r, 1);
    check("mux_wait_oe_l", bus.siod_oe_l, 1);
    check("mux_wait_oe_r", bus.siod_oe_r, 0);
    check("mux_wait_siod_i", bus.ctl_siod_i, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    check("midrst_sioc_l", bus.sioc_l, 1);

    check("cam_sel_stable", sel_glitches, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
